// File: rtl/i2s_rx_if.sv
// i2s_rx_if: bundle of the I2S capture serial inputs and the parallel sample outputs.
//   i2s_SCLK   bit clock copy (asynchronous to the system clock)
//   i2s_LRCK   word clock, 0 = left, 1 = right
//   i2s_SDATA  serial ADC data, MSB first
//   L_data     last complete left sample
//   R_data     last complete right sample
//   valid      one-cycle pulse when L_data/R_data update
//   frame_err  one-cycle pulse when a word is truncated
// master: codec / consumer side. slave: the receiver.
interface i2s_rx_if #(
  parameter int unsigned WIDTH = 16
);
  logic             i2s_SCLK;
  logic             i2s_LRCK;
  logic             i2s_SDATA;
  logic [WIDTH-1:0] L_data;
  logic [WIDTH-1:0] R_data;
  logic             valid;
  logic             frame_err;

  modport master (
    output i2s_SCLK,
    output i2s_LRCK,
    output i2s_SDATA,
    input  L_data,
    input  R_data,
    input  valid,
    input  frame_err
  );

  modport slave (
    input  i2s_SCLK,
    input  i2s_LRCK,
    input  i2s_SDATA,
    output L_data,
    output R_data,
    output valid,
    output frame_err
  );
endinterface

// File: rtl/i2s_rx.sv
// i2s_rx: Philips-I2S stereo capture into the system clock domain.
// Oversamples the codec bit clock, word clock and ADC data, deserialises left/right
// words and emits one valid strobe per complete stereo pair.
//   clk_50MHz  system clock, all logic on its rising edge
//   reset      asynchronous, active-high reset
//   bus        i2s_rx_if slave: serial inputs in, L_data/R_data/valid/frame_err out
// Pipeline: synchronisers -> bit-event sample -> word FSM -> frame/output stage.
// valid/frame_err appear SYNC_STAGES+2 cycles after the first clock that sees SCLK high.
module i2s_rx #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic     clk_50MHz,
  input logic     reset,
  i2s_rx_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StSync,
    StCapture,
    StHold
  } state_e;

  // ---------------------------------------------------------------------------
  // Synchronisers and bit-event detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] lrck_sync_q;
  logic [SYNC_STAGES-1:0] sdata_sync_q;
  logic                   sclk_dly_q;
  logic                   bit_rise;

  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      sclk_sync_q  <= '0;
      lrck_sync_q  <= '0;
      sdata_sync_q <= '0;
      sclk_dly_q   <= 1'b0;
    end else begin
      sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], bus.i2s_SCLK};
      lrck_sync_q  <= {lrck_sync_q[SYNC_STAGES-2:0], bus.i2s_LRCK};
      sdata_sync_q <= {sdata_sync_q[SYNC_STAGES-2:0], bus.i2s_SDATA};
      sclk_dly_q   <= sclk_sync_q[SYNC_STAGES-1];
    end
  end

  assign bit_rise = sclk_sync_q[SYNC_STAGES-1] & ~sclk_dly_q;

  // LRCK and SDATA are captured together on the bit event.
  logic bit_ev_q;
  logic lr_smp_q;
  logic sd_smp_q;

  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      bit_ev_q <= 1'b0;
      lr_smp_q <= 1'b0;
      sd_smp_q <= 1'b0;
    end else begin
      bit_ev_q <= bit_rise;
      if (bit_rise) begin
        lr_smp_q <= lrck_sync_q[SYNC_STAGES-1];
        sd_smp_q <= sdata_sync_q[SYNC_STAGES-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Word FSM
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [WIDTH-1:0]  sh_q, sh_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              ch_q, ch_d;
  logic              lr_prev_q;
  logic              change;
  logic [WIDTH-1:0]  shifted;

  // Events handed to the frame stage.
  logic              cmp_q, cmp_d;
  logic              cmp_ch_q, cmp_ch_d;
  logic [WIDTH-1:0]  word_q, word_d;
  logic              err_q, err_d;
  logic              clr_q, clr_d;

  assign change  = bit_ev_q & (lr_smp_q != lr_prev_q);
  assign shifted = {sh_q[WIDTH-2:0], sd_smp_q};

  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      state_q   <= StSync;
      sh_q      <= '0;
      cnt_q     <= '0;
      ch_q      <= 1'b0;
      lr_prev_q <= 1'b0;
      cmp_q     <= 1'b0;
      cmp_ch_q  <= 1'b0;
      word_q    <= '0;
      err_q     <= 1'b0;
      clr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      ch_q     <= ch_d;
      cmp_q    <= cmp_d;
      cmp_ch_q <= cmp_ch_d;
      word_q   <= word_d;
      err_q    <= err_d;
      clr_q    <= clr_d;
      if (bit_ev_q) begin
        lr_prev_q <= lr_smp_q;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    ch_d     = ch_q;
    cmp_d    = 1'b0;
    cmp_ch_d = ch_q;
    word_d   = shifted;
    err_d    = 1'b0;
    clr_d    = 1'b0;

    unique case (state_q)
      StSync: begin
        // Only the start of a left word brings us into frame.
        if (change && !lr_smp_q) begin
          cnt_d   = '0;
          ch_d    = 1'b0;
          clr_d   = 1'b1;
          state_d = StCapture;
        end
      end

      StCapture: begin
        if (change) begin
          // The bit on the LRCK transition edge is the LSB of the word just ending.
          if (cnt_q == CntLast) begin
            cmp_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          cnt_d = '0;
          ch_d  = lr_smp_q;
        end else if (bit_ev_q) begin
          sh_d  = shifted;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntLast) begin
            cmp_d   = 1'b1;
            state_d = StHold;
          end
        end
      end

      StHold: begin
        // Remaining slot bits are padding; the edge bit of the new word is not data.
        if (change) begin
          cnt_d   = '0;
          ch_d    = lr_smp_q;
          state_d = StCapture;
        end
      end

      default: begin
        state_d = StSync;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Frame pairing and outputs
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] lh_q;
  logic             lok_q;
  logic [WIDTH-1:0] l_data_q;
  logic [WIDTH-1:0] r_data_q;
  logic             valid_q;
  logic             ferr_q;

  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      lh_q     <= '0;
      lok_q    <= 1'b0;
      l_data_q <= '0;
      r_data_q <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      if (cmp_q) begin
        if (!cmp_ch_q) begin
          lh_q  <= word_q;
          lok_q <= 1'b1;
        end else if (lok_q) begin
          l_data_q <= lh_q;
          r_data_q <= word_q;
          valid_q  <= 1'b1;
          lok_q    <= 1'b0;
        end
      end
      // A right word without a preceding left word in this frame is dropped silently.
      if (err_q || clr_q) begin
        lok_q <= 1'b0;
      end
      if (err_q) begin
        ferr_q <= 1'b1;
      end
    end
  end

  assign bus.L_data    = l_data_q;
  assign bus.R_data    = r_data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = ferr_q;

endmodule
